// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around the port arbiter.
// No storage; pure wiring.
// Handshakes: req/gnt on both clients, req/ready on the memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic                i_unused_pad;
  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ready;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  logic                busy;

  // arbiter side
  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy
  );

  // environment side: both clients plus the memory
  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction outstanding.
// Latency: mem_req 1 cycle after request; response passed through combinationally from mem_rvalid.
// Backpressure: command held in ISSUE until mem_ready; clients hold req until their gnt.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_i_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              kill_q;
  logic [CNT_W-1:0]  starve_q;

  logic any_req, starved, pick_i, accept, resp, flush_hit;

  assign any_req   = bus.i_req | bus.d_req;
  assign starved   = (starve_q == LIMIT);
  // data wins unless fetch has been starved for STARVE_LIMIT data grants
  assign pick_i    = bus.i_req & (~bus.d_req | starved);
  assign flush_hit = owner_i_q & bus.i_flush & (state_q != IDLE);

  // next-state and handshake strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    resp    = 1'b0;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (bus.mem_ready) begin accept = 1'b1; state_d = WAIT; end
      WAIT:    if (bus.mem_rvalid) begin resp = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  // state, starvation counter and fetch-kill flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (!bus.i_req)        starve_q <= '0;
        else if (pick_i)       starve_q <= '0;
        else if (!starved)     starve_q <= starve_q + CNT_W'(1);
      end
      // a killed fetch still drains its memory response; flag drops with it
      if (resp)           kill_q <= 1'b0;
      else if (flush_hit) kill_q <= 1'b1;
    end
  end

  // command latch, captured at arbitration and held through ISSUE/WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_i_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_i_q <= pick_i;
      addr_q    <= pick_i ? bus.i_addr : bus.d_addr;
      we_q      <= ~pick_i & bus.d_we;
      wdata_q   <= pick_i ? '0 : bus.d_wdata;
      be_q      <= pick_i ? '1 : bus.d_be;
    end
  end

  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.busy      = (state_q != IDLE);

  // a flush landing in the accept or response cycle kills the fetch immediately
  assign bus.i_gnt    = accept & owner_i_q & ~kill_q & ~bus.i_flush;
  assign bus.d_gnt    = accept & ~owner_i_q;
  assign bus.i_rvalid = resp & owner_i_q & ~kill_q & ~bus.i_flush;
  assign bus.d_rvalid = resp & ~owner_i_q;
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a command/response scoreboard.
// Acts as both clients and the memory; checks at posedge+2.
// Memory ready/response timing is set per transaction.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_i;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    bit          is_i;
    bit          vld;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] addr);
    cmd_t c;
    c.is_i = 1'b1; c.addr = addr; c.we = 1'b0; c.wdata = '0; c.be = 4'hF;
    cmd_q.push_back(c);
  endtask

  task automatic push_d(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be);
    cmd_t c;
    c.is_i = 1'b0; c.addr = addr; c.we = we; c.wdata = wdata; c.be = be;
    cmd_q.push_back(c);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
    chk({tag, "_busy"},    64'(bus.busy),    64'd0);
    chk({tag, "_i_gnt"},   64'(bus.i_gnt),   64'd0);
    chk({tag, "_d_gnt"},   64'(bus.d_gnt),   64'd0);
    chk({tag, "_i_rv"},    64'(bus.i_rvalid), 64'd0);
    chk({tag, "_d_rv"},    64'(bus.d_rvalid), 64'd0);
  endtask

  // Called with the DUT in IDLE and requests already driven. Walks ISSUE
  // (ready_lat stall cycles) and WAIT (rsp_lat cycles before mem_rvalid).
  task automatic do_txn(input int ready_lat, input int rsp_lat, input bit flush_issue,
                        input bit flush_wait, input bit drop_i, input bit drop_d);
    cmd_t        e;
    rsp_t        r;
    logic [31:0] rd;
    bit          killed;
    if (cmd_q.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL sb_empty observed=0 expected=1 queued commands");
      return;
    end
    e = cmd_q.pop_front();
    killed = e.is_i && (flush_issue || flush_wait);
    for (int c = 0; c <= ready_lat; c++) begin
      step();
      bus.mem_ready = (c == ready_lat);
      bus.i_flush   = flush_issue && (c == 0);
      if (flush_issue && c == 0) bus.i_req = 1'b0;
      #1;
      chk("issue_mem_req", 64'(bus.mem_req), 64'd1);
      chk("issue_addr",    64'(bus.mem_addr), 64'(e.addr));
      chk("issue_we",      64'(bus.mem_we), 64'(e.we));
      chk("issue_be",      64'(bus.mem_be), 64'(e.be));
      if (!e.is_i) chk("issue_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
      chk("issue_i_gnt", 64'(bus.i_gnt), 64'(e.is_i && !flush_issue && c == ready_lat));
      chk("issue_d_gnt", 64'(bus.d_gnt), 64'(!e.is_i && c == ready_lat));
    end
    for (int c = 0; c <= rsp_lat; c++) begin
      step();
      if (c == 0) begin
        bus.mem_ready = 1'b0;
        if (drop_i) bus.i_req = 1'b0;
        if (drop_d) bus.d_req = 1'b0;
      end
      bus.i_flush    = flush_wait && (c == 0);
      bus.mem_rvalid = (c == rsp_lat);
      rd             = $urandom;
      bus.mem_rdata  = rd;
      if (c == rsp_lat) rsp_q.push_back('{e.is_i, !killed, rd});
      #1;
      chk("wait_mem_req", 64'(bus.mem_req), 64'd0);
      chk("wait_busy",    64'(bus.busy),    64'd1);
      chk("wait_gnts",    64'({bus.i_gnt, bus.d_gnt}), 64'd0);
      if (c == rsp_lat) begin
        r = rsp_q.pop_front();
        chk("rsp_i_rvalid", 64'(bus.i_rvalid), 64'(r.is_i && r.vld));
        chk("rsp_d_rvalid", 64'(bus.d_rvalid), 64'(!r.is_i && r.vld));
        if (r.vld) chk("rsp_rdata", 64'(r.is_i ? bus.i_rdata : bus.d_rdata), 64'(r.data));
      end else begin
        chk("wait_rvalids", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
      end
    end
    step();
    bus.mem_rvalid = 1'b0;
    bus.i_flush    = 1'b0;
    #1;
    chk_idle("post");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0F00; bus.i_flush = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0E00;
    bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hF;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;

    // reset with every input active: outputs and latched fields stay zero
    step(); step();
    #1;
    chk_idle("reset");
    chk("reset_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("reset_mem_be",    64'(bus.mem_be),    64'd0);
    chk("reset_mem_we",    64'(bus.mem_we),    64'd0);
    step();
    reset = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
    step();

    // fetch only, ready immediately, response one cycle after accept
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    push_i(32'h0000_1000);
    #1;
    chk("t1_cycle0_mem_req", 64'(bus.mem_req), 64'd0);
    do_txn(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // store with 3 stall cycles
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2000;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    push_d(32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 4'h3);
    do_txn(3, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // load with a slow response
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2104;
    bus.d_wdata = 32'h0; bus.d_be = 4'hC;
    push_d(32'h0000_2104, 1'b0, 32'h0, 4'hC);
    do_txn(1, 2, 1'b0, 1'b0, 1'b0, 1'b1);

    // both held: four data wins, then fetch, then data again
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_4000;
    bus.d_wdata = 32'h0000_0055; bus.d_be = 4'hF;
    for (int k = 0; k < 4; k++) push_d(32'h0000_4000, 1'b0, 32'h0000_0055, 4'hF);
    push_i(32'h0000_3000);
    push_d(32'h0000_4000, 1'b0, 32'h0000_0055, 4'hF);
    for (int k = 0; k < 5; k++) do_txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_txn(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // flush in WAIT kills the fetch response; next data access is normal
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_5000;
    push_i(32'h0000_5000);
    do_txn(0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_6000; bus.d_be = 4'hF;
    push_d(32'h0000_6000, 1'b0, bus.d_wdata, 4'hF);
    do_txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // flush coinciding with mem_rvalid
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_7000;
    push_i(32'h0000_7000);
    do_txn(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // flush in ISSUE suppresses i_gnt and the response
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_7100;
    push_i(32'h0000_7100);
    do_txn(2, 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // flush while data owns the port has no effect
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_8000;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_be = 4'h9;
    push_d(32'h0000_8000, 1'b1, 32'hCAFE_F00D, 4'h9);
    do_txn(0, 1, 1'b0, 1'b1, 1'b0, 1'b1);

    // flush in IDLE alongside a fetch request has no effect
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_9000; bus.i_flush = 1'b1;
    push_i(32'h0000_9000);
    do_txn(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset while waiting: stale response ignored, then a fresh fetch completes
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_A000;
    step();
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0; bus.i_req = 1'b0;
    #1;
    chk("t9_in_wait_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    #1;
    chk_idle("t9_stale");
    chk("t9_mem_addr", 64'(bus.mem_addr), 64'd0);
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    chk_idle("t9_after");
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_B000;
    push_i(32'h0000_B000);
    do_txn(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    chk("sb_cmd_drained", 64'(cmd_q.size()), 64'd0);
    chk("sb_rsp_drained", 64'(rsp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
